mem_arbiter: RTL and testbench

Two-port arbiter sharing the single instruction/data memory port between the I-cache controller (read-only refills) and the D-cache controller (refills and write-backs). It sits between both cache controllers and the external memory. It grants one transaction at a time using round-robin, holds the memory request stable until memory completes, and routes the result back with the same busywait handshake the caches already use. A watchdog bounds each memory access.

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache.
// Holds each request stable until memory completes; a watchdog bounds WAIT.
module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ic_read,
   input  logic [31:0] ic_address,
   output logic [31:0] ic_readdata,
   output logic        ic_busywait,
   output logic        ic_error,
   input  logic        dc_read,
   input  logic        dc_write,
   input  logic [31:0] dc_address,
   input  logic [31:0] dc_writedata,
   output logic [31:0] dc_readdata,
   output logic        dc_busywait,
   output logic        dc_error,
   output logic        mem_read_req,
   output logic        mem_write_req,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata,
   input  logic        mem_busywait
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   typedef enum logic {
      GNT_IC,
      GNT_DC
   } gnt_t;

   state_t        state;
   gnt_t          gnt;
   gnt_t          last_grant;
   logic [CW-1:0] cnt;
   logic          dc_req;
   logic          pick_dc;

   assign dc_req = dc_read | dc_write;

   // On a tie the port not served last wins.
   always_comb begin
      pick_dc = dc_req;
      if (ic_read && dc_req)
         pick_dc = (last_grant == GNT_IC);
   end

   assign ic_busywait = ic_read &
      ~((state == DONE) && (gnt == GNT_IC));
   assign dc_busywait = dc_req &
      ~((state == DONE) && (gnt == GNT_DC));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         gnt           <= GNT_IC;
         last_grant    <= GNT_IC;
         cnt           <= '0;
         mem_read_req  <= 1'b0;
         mem_write_req <= 1'b0;
         mem_address   <= '0;
         mem_writedata <= '0;
         ic_readdata   <= '0;
         dc_readdata   <= '0;
         ic_error      <= 1'b0;
         dc_error      <= 1'b0;
      end else begin
         ic_error <= 1'b0;
         dc_error <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ic_read || dc_req) begin
                  state <= ISSUE;
                  if (pick_dc) begin
                     gnt           <= GNT_DC;
                     mem_address   <= dc_address;
                     mem_writedata <= dc_writedata;
                     mem_write_req <= dc_write;
                     mem_read_req  <= ~dc_write;
                  end else begin
                     gnt           <= GNT_IC;
                     mem_address   <= ic_address;
                     mem_write_req <= 1'b0;
                     mem_read_req  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               if (!mem_busywait) begin
                  mem_read_req  <= 1'b0;
                  mem_write_req <= 1'b0;
                  state         <= DONE;
                  if (mem_read_req) begin
                     if (gnt == GNT_DC)
                        dc_readdata <= mem_readdata;
                     else
                        ic_readdata <= mem_readdata;
                  end
               end else if (cnt == CNT_LAST) begin
                  // Watchdog expired: abort and flag the owner.
                  mem_read_req  <= 1'b0;
                  mem_write_req <= 1'b0;
                  cnt           <= CNT_MAX;
                  state         <= DONE;
                  if (gnt == GNT_DC) begin
                     dc_error <= 1'b1;
                     if (mem_read_req)
                        dc_readdata <= '0;
                  end else begin
                     ic_error <= 1'b1;
                     if (mem_read_req)
                        ic_readdata <= '0;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               last_grant <= gnt;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ic_read;
   logic [31:0] ic_address;
   logic [31:0] ic_readdata;
   logic        ic_busywait;
   logic        ic_error;
   logic        dc_read;
   logic        dc_write;
   logic [31:0] dc_address;
   logic [31:0] dc_writedata;
   logic [31:0] dc_readdata;
   logic        dc_busywait;
   logic        dc_error;
   logic        mem_read_req;
   logic        mem_write_req;
   logic [31:0] mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   int nvec = 0;
   int nerr = 0;

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .ic_read      (ic_read),
      .ic_address   (ic_address),
      .ic_readdata  (ic_readdata),
      .ic_busywait  (ic_busywait),
      .ic_error     (ic_error),
      .dc_read      (dc_read),
      .dc_write     (dc_write),
      .dc_address   (dc_address),
      .dc_writedata (dc_writedata),
      .dc_readdata  (dc_readdata),
      .dc_busywait  (dc_busywait),
      .dc_error     (dc_error),
      .mem_read_req (mem_read_req),
      .mem_write_req(mem_write_req),
      .mem_address  (mem_address),
      .mem_writedata(mem_writedata),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   always #5 clk = ~clk;

   // Memory model: busy for lat negedges after the request is seen.
   int lat = 0;
   bit hang = 0;
   bit act = 0;
   int left = 0;
   always @(negedge clk) begin
      if (!(mem_read_req || mem_write_req)) begin
         act = 0;
         mem_busywait = 1'b0;
      end else if (!act) begin
         act = 1;
         left = lat;
         mem_busywait = hang || (lat != 0);
      end else if (left > 0) begin
         left--;
         if (left == 0 && !hang)
            mem_busywait = 1'b0;
      end
   end

   int rd_cyc, wr_cyc, rd_win, wr_win, dc_err_cyc;
   logic [31:0] last_addr, last_wd;
   bit prev_req = 0;
   bit dcbw_seen;
   always @(negedge clk) begin
      if (mem_read_req) rd_cyc++;
      if (mem_write_req) wr_cyc++;
      if ((mem_read_req || mem_write_req) && !prev_req) begin
         if (mem_read_req) rd_win++;
         else wr_win++;
         last_addr = mem_address;
         last_wd = mem_writedata;
      end
      prev_req = mem_read_req || mem_write_req;
      if (dc_busywait) dcbw_seen = 1;
      if (dc_error) dc_err_cyc++;
   end

   task automatic clr_stats();
      rd_cyc = 0;
      wr_cyc = 0;
      rd_win = 0;
      wr_win = 0;
      dc_err_cyc = 0;
      last_addr = '0;
      last_wd = '0;
      dcbw_seen = 0;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Negedges until the port's busywait drops; -1 if it never does.
   task automatic wait_free(input bit dc, output int n);
      n = 0;
      repeat (60) begin
         @(negedge clk);
         n++;
         if (dc ? !dc_busywait : !ic_busywait) return;
      end
      n = -1;
   endtask

   int n;
   int seq[4];
   int ev;

   initial begin
      reset = 1'b0;
      ic_read = 0;
      dc_read = 0;
      dc_write = 0;
      ic_address = '0;
      dc_address = '0;
      dc_writedata = '0;
      mem_readdata = '0;
      mem_busywait = 1'b0;
      clr_stats();

      // Reset state
      @(negedge clk); #1;
      chk("rst_rd_req", mem_read_req, 0);
      chk("rst_wr_req", mem_write_req, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_wdata", mem_writedata, 0);
      chk("rst_ic_rdata", ic_readdata, 0);
      chk("rst_dc_rdata", dc_readdata, 0);
      chk("rst_errs", {ic_error, dc_error}, 0);
      chk("rst_bw_idle", {ic_busywait, dc_busywait}, 0);
      ic_read = 1;
      #1 chk("rst_ic_bw_follow", ic_busywait, 1);
      ic_read = 0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;

      // Single I-cache read, 3 busy cycles
      clr_stats();
      ic_read = 1;
      ic_address = 32'h40;
      lat = 3;
      mem_readdata = 32'h13;
      wait_free(0, n); #1;
      chk("ic_lat", n, 5);
      chk("ic_rdata", ic_readdata, 32'h13);
      chk("ic_done_req", mem_read_req, 0);
      chk("ic_rd_win", rd_win, 1);
      chk("ic_rd_cyc", rd_cyc, 4);
      chk("ic_addr", last_addr, 32'h40);
      chk("ic_no_wr", wr_cyc, 0);
      chk("ic_dc_bw", dcbw_seen, 0);
      ic_read = 0;
      @(negedge clk); #1;

      // D-cache read, then write must leave readdata alone
      clr_stats();
      dc_read = 1;
      dc_address = 32'h104;
      lat = 1;
      mem_readdata = 32'h11112222;
      wait_free(1, n); #1;
      chk("dcr_lat", n, 3);
      chk("dcr_rdata", dc_readdata, 32'h11112222);
      dc_read = 0;
      @(negedge clk); #1;
      clr_stats();
      dc_write = 1;
      dc_address = 32'h100;
      dc_writedata = 32'hCAFEF00D;
      lat = 2;
      mem_readdata = 32'hBAD0BAD0;
      wait_free(1, n); #1;
      chk("dcw_lat", n, 4);
      chk("dcw_win", wr_win, 1);
      chk("dcw_addr", last_addr, 32'h100);
      chk("dcw_data", last_wd, 32'hCAFEF00D);
      chk("dcw_no_rd", rd_cyc, 0);
      chk("dcw_rdata_hold", dc_readdata, 32'h11112222);
      dc_write = 0;
      @(negedge clk); #1;

      // Fresh reset, then both ports request continuously
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      clr_stats();
      lat = 1;
      mem_readdata = 32'h33;
      ic_read = 1;
      ic_address = 32'hA0;
      dc_read = 1;
      dc_address = 32'hD0;
      ev = 0;
      repeat (80) begin
         @(negedge clk);
         if (ev < 4) begin
            if (!ic_busywait && !dc_busywait) begin
               seq[ev] = 2;
               ev++;
            end else if (!dc_busywait) begin
               seq[ev] = 1;
               ev++;
            end else if (!ic_busywait) begin
               seq[ev] = 0;
               ev++;
            end
         end
      end
      #1;
      chk("rr_events", ev, 4);
      chk("rr_0_dc", seq[0], 1);
      chk("rr_1_ic", seq[1], 0);
      chk("rr_2_dc", seq[2], 1);
      chk("rr_3_ic", seq[3], 0);
      ic_read = 0;
      dc_read = 0;
      @(negedge clk);
      @(negedge clk); #1;

      // Watchdog: memory never completes
      clr_stats();
      hang = 1;
      mem_readdata = 32'hDEAD0000;
      dc_read = 1;
      dc_address = 32'h200;
      wait_free(1, n); #1;
      chk("to_lat", n, 10);
      chk("to_err", dc_error, 1);
      chk("to_ic_err", ic_error, 0);
      chk("to_rdata", dc_readdata, 0);
      chk("to_req_low", mem_read_req, 0);
      dc_read = 0;
      hang = 0;
      @(negedge clk); #1;
      chk("to_err_gone", dc_error, 0);
      chk("to_err_cyc", dc_err_cyc, 1);
      clr_stats();
      dc_read = 1;
      dc_address = 32'h204;
      lat = 0;
      mem_readdata = 32'h5555AAAA;
      wait_free(1, n); #1;
      chk("post_to_lat", n, 3);
      chk("post_to_rdata", dc_readdata, 32'h5555AAAA);
      chk("post_to_err", dc_error, 0);
      dc_read = 0;
      @(negedge clk); #1;

      // Reset during WAIT
      clr_stats();
      ic_read = 1;
      ic_address = 32'h300;
      lat = 5;
      mem_readdata = 32'h77;
      @(negedge clk);
      @(negedge clk); #1;
      chk("rw_req_on", mem_read_req, 1);
      reset = 1'b0;
      #1;
      chk("rw_async_drop", mem_read_req, 0);
      chk("rw_addr_clr", mem_address, 0);
      chk("rw_bw_held", ic_busywait, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rw_reissue", mem_read_req, 1);
      chk("rw_readdr", mem_address, 32'h300);
      wait_free(0, n); #1;
      chk("rw_lat", n, 6);
      chk("rw_rdata", ic_readdata, 32'h77);
      ic_read = 0;
      @(negedge clk); #1;

      // Read and write together is a write
      clr_stats();
      dc_read = 1;
      dc_write = 1;
      dc_address = 32'h400;
      dc_writedata = 32'h12345678;
      lat = 1;
      mem_readdata = 32'hFFFF0000;
      wait_free(1, n); #1;
      chk("rw2_lat", n, 3);
      chk("rw2_wr_win", wr_win, 1);
      chk("rw2_no_rd", rd_cyc, 0);
      chk("rw2_data", last_wd, 32'h12345678);
      chk("rw2_rdata_hold", dc_readdata, 0);
      dc_read = 0;
      dc_write = 0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
